// File: rtl/wc_tile_scheduler.sv
// Tile scheduler for the F(3,5) Winograd datapath. It slides a 7-sample window with
// a stride of 3, issues windows to wc and captures wc's results into a tile FIFO after
// the fixed pipeline latency. It then streams the results out as y0,y1,y2 per tile.
module wc_tile_scheduler #(
  parameter int unsigned DW         = 10,
  parameter int unsigned LAT        = 2,
  parameter int unsigned FIFO_TILES = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [15:0]     num_tiles,
  input  logic            in_valid,
  input  logic [DW-1:0]   in_data,
  output logic            in_ready,
  output logic [7*DW-1:0] wc_d,
  input  logic [3*DW-1:0] wc_z,
  output logic            out_valid,
  output logic [DW-1:0]   out_data,
  input  logic            out_ready,
  output logic            out_last,
  output logic            busy,
  output logic            done
);

  localparam int unsigned PtrW = (FIFO_TILES > 1) ? $clog2(FIFO_TILES) : 1;
  localparam int unsigned CntW = $clog2(FIFO_TILES + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e          state_q, state_d;
  logic [15:0]     num_tiles_q, issued_q, emitted_q;
  logic [2:0]      need_q;
  logic [7*DW-1:0] win_q;
  logic [LAT-1:0]  tag_q, tag_d;
  logic [3*DW-1:0] fifo_q [FIFO_TILES];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] fifo_cnt_q;
  logic [1:0]      idx_q;
  logic [3*DW-1:0] head;

  logic        accept, issue, last_issue, capture, out_hs, pop;
  int unsigned occupancy;

  // Handshakes, issue gating and the tag pipe shift.
  always_comb begin
    // Tiles already owning a FIFO slot: stored results plus those still inside wc.
    occupancy = 32'(fifo_cnt_q);
    for (int i = 0; i < LAT; i++) occupancy = occupancy + 32'(tag_q[i]);
    in_ready   = (state_q == StRun) && (need_q != 3'd0);
    accept     = in_valid && in_ready;
    issue      = (state_q == StRun) && (need_q == 3'd0) && (occupancy < FIFO_TILES);
    last_issue = issue && (issued_q == num_tiles_q - 16'd1);
    capture    = tag_q[LAT-1];
    out_valid  = (fifo_cnt_q != '0);
    out_hs     = out_valid && out_ready;
    pop        = out_hs && (idx_q == 2'd2);
    out_last   = out_valid && (idx_q == 2'd2) && (emitted_q == num_tiles_q - 16'd1);
    tag_d      = '0;
    tag_d[0]   = issue;
    for (int i = 1; i < LAT; i++) tag_d[i] = tag_q[i-1];
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // FSM next state; the final y2 handshake is the moment the FIFO, tag pipe and
  // serialiser all become empty.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = (num_tiles == 16'd0) ? StDone : StRun;
      StRun:   if (last_issue) state_d = StDrain;
      StDrain: if (pop && out_last) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy = (state_q != StIdle);
    done = (state_q == StDone);
  end

  // Job counters, sample window, tag pipe and result FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      num_tiles_q <= '0;
      issued_q    <= '0;
      emitted_q   <= '0;
      need_q      <= '0;
      win_q       <= '0;
      tag_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fifo_cnt_q  <= '0;
      idx_q       <= '0;
      for (int i = 0; i < FIFO_TILES; i++) fifo_q[i] <= '0;
    end else begin
      if (state_q == StIdle && start) begin
        num_tiles_q <= num_tiles;
        need_q      <= 3'd7;
        issued_q    <= '0;
        emitted_q   <= '0;
      end else begin
        if (accept) need_q <= need_q - 3'd1;
        if (issue) begin
          issued_q <= issued_q + 16'd1;
          need_q   <= last_issue ? 3'd0 : 3'd3;
        end
        if (pop) emitted_q <= emitted_q + 16'd1;
      end
      if (accept) win_q <= {win_q[6*DW-1:0], in_data};
      tag_q <= tag_d;
      if (capture) begin
        fifo_q[wr_ptr_q] <= wc_z;
        wr_ptr_q <= (wr_ptr_q == PtrW'(FIFO_TILES - 1)) ? '0 : wr_ptr_q + PtrW'(1);
      end
      if (pop) rd_ptr_q <= (rd_ptr_q == PtrW'(FIFO_TILES - 1)) ? '0 : rd_ptr_q + PtrW'(1);
      if (out_hs) idx_q <= pop ? 2'd0 : idx_q + 2'd1;
      fifo_cnt_q <= fifo_cnt_q + CntW'(capture) - CntW'(pop);
    end
  end

  // Window drives wc directly; output word is selected from the FIFO head in place,
  // so a tile keeps its slot until its y2 is taken.
  always_comb begin
    wc_d     = win_q;
    head     = fifo_q[rd_ptr_q];
    out_data = '0;
    if (out_valid) begin
      case (idx_q)
        2'd0:    out_data = head[3*DW-1 -: DW];
        2'd1:    out_data = head[2*DW-1 -: DW];
        default: out_data = head[DW-1:0];
      endcase
    end
  end

endmodule
